// File: rtl/led_pattern_gen_pkg.sv
// Shared types and constants for the LED pattern generator.
// Mode encoding, FSM state type and default widths.
package led_pattern_gen_pkg;

  localparam int DEF_PER_W = 8;
  localparam int DEF_CNT_W = 4;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    STEADY,
    ON_PH,
    OFF_PH
  } state_e;

endpackage

// File: rtl/led_pattern_gen_phase_timer.sv
// led_phase_timer: ce-gated tick counter with a phase-end strobe.
// A period of 0 behaves as 1; compare before increment, so no wrap.
module led_phase_timer
  import led_pattern_gen_pkg::*;
#(
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             run,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             phase_end
);

  localparam logic [PER_W-1:0] ONE = PER_W'(1);

  logic [PER_W-1:0] tick_cnt_q;
  logic [PER_W-1:0] tick_cnt_d;
  logic [PER_W-1:0] last;

  // Phase ends on the tick that reaches period-1; clr wins over ce.
  always_comb begin
    last       = (period == '0) ? '0 : period - ONE;
    phase_end  = run && ce && !clr && (tick_cnt_q == last);
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (run && ce) begin
      tick_cnt_d = phase_end ? '0 : tick_cnt_q + ONE;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: turns handshaked commands into timed LED patterns.
// Optional LED_PWM_EN dims led_out with a 16-step free-running PWM.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int PER_W    = DEF_PER_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PWM_DUTY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [PER_W-1:0] cmd_period,
  output logic             led_out,
  output logic             busy,
  output logic             done
);

  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             accept;
  logic             run;
  logic             phase_end;
  logic             phase_on_d;
  logic [CNT_W:0]   rep_nxt;

  // Ready in IDLE, STEADY and continuous blink; finite patterns block.
  always_comb begin
    cmd_ready = 1'b0;
    unique case (1'b1)
      state_q == IDLE:   cmd_ready = 1'b1;
      state_q == STEADY: cmd_ready = 1'b1;
      default: cmd_ready = (mode_q == MODE_BLINK) && (cnt_q == '0);
    endcase
  end

  assign accept  = cmd_valid && cmd_ready;
  assign run     = (state_q == ON_PH) || (state_q == OFF_PH);
  assign rep_nxt = {1'b0, rep_q} + 1'b1;

  led_phase_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .run      (run),
    .clr      (accept),
    .period   (per_q),
    .phase_end(phase_end)
  );

  // Next state: accept/preempt first, otherwise advance on phase ends.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    if (accept) begin
      mode_d = cmd_mode;
      cnt_d  = cmd_count;
      per_d  = (cmd_period == '0) ? PER_ONE : cmd_period;
      rep_d  = '0;
      unique case (cmd_mode)
        MODE_OFF: state_d = IDLE;
        MODE_ON:  state_d = STEADY;
        default:  state_d = ON_PH;
      endcase
    end else if (phase_end) begin
      unique case (state_q)
        ON_PH: begin
          if (mode_q == MODE_PULSE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = OFF_PH;
          end
        end
        OFF_PH: begin
          if (cnt_q == '0) begin
            state_d = ON_PH;
          end else if (rep_nxt < {1'b0, cnt_q}) begin
            state_d = ON_PH;
            rep_d   = rep_nxt[CNT_W-1:0];
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign phase_on_d = (state_d == STEADY) || (state_d == ON_PH);

`ifdef LED_PWM_EN
  localparam logic [4:0] DUTY = 5'(PWM_DUTY);

  logic [3:0] pwm_cnt_q;
  logic [3:0] pwm_cnt_d;

  // Dim the lit phases with the next PWM count so led_out stays aligned.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    led_d     = phase_on_d && ({1'b0, pwm_cnt_d} < DUTY);
  end

  // Free-running PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end
`else
  // Without dimming the LED follows the lit phase; zero duty stays dark.
  always_comb begin
    led_d = phase_on_d && (PWM_DUTY != 0);
  end
`endif

  // Pattern state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_OFF;
      cnt_q   <= '0;
      per_q   <= PER_ONE;
      rep_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      rep_q   <= rep_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led_out = led_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: table vectors, corner
// sequences and random commands against an elapsed-tick model.
module tb_led_pattern_gen;
  import led_pattern_gen_pkg::*;

  localparam int PER_W    = 8;
  localparam int CNT_W    = 4;
  localparam int PWM_DUTY = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic [PER_W-1:0] cmd_period;
  logic             led_out;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .PER_W   (PER_W),
    .CNT_W   (CNT_W),
    .PWM_DUTY(PWM_DUTY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .cmd_period(cmd_period),
    .led_out   (led_out),
    .busy      (busy),
    .done      (done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: kind 0 idle, 1 steady, 2 blink, 3 pulse; m_el = ce ticks
  // counted since acceptance.
  int m_kind, m_cnt, m_per, m_el, m_edges;
  bit m_done;

  task automatic m_reset();
    m_kind  = 0;
    m_cnt   = 0;
    m_per   = 1;
    m_el    = 0;
    m_edges = 0;
    m_done  = 0;
  endtask

  function automatic bit m_ready();
    return (m_kind == 0) || (m_kind == 1) ||
           (m_kind == 2 && m_cnt == 0);
  endfunction

  function automatic bit m_led();
    bit ph;
    ph = (m_kind == 1) ||
         (m_kind >= 2 && (m_el % (2 * m_per)) < m_per);
`ifdef LED_PWM_EN
    return ph && ((m_edges % 16) < PWM_DUTY);
`else
    return ph;
`endif
  endfunction

  task automatic model_edge();
    int total;
    m_edges++;
    m_done = 0;
    if (cmd_valid && m_ready()) begin
      m_kind = int'(cmd_mode);
      m_cnt  = int'(cmd_count);
      m_per  = (cmd_period == 0) ? 1 : int'(cmd_period);
      m_el   = 0;
    end else if (m_kind >= 2 && ce) begin
      m_el++;
      if (m_kind == 2 && m_cnt == 0) begin
        m_el = m_el % (2 * m_per);
      end else begin
        total = (m_kind == 2) ? 2 * m_per * m_cnt : m_per;
        if (m_el == total) begin
          m_kind = 0;
          m_el   = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("led_out", int'(led_out), int'(m_led()));
    chk("cmd_ready", int'(cmd_ready), int'(m_ready()));
    chk("busy", int'(busy), int'(m_kind != 0));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(bit v, logic [1:0] md, int c, int p);
    cmd_valid  = v;
    cmd_mode   = md;
    cmd_count  = CNT_W'(c);
    cmd_period = PER_W'(p);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         count;
    int         period;
    int         ce_div;
    int         exp_high;
    int         exp_done;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(vec_t v, int idx);
    int  high;
    int  done_at;
    bit  saw_ready;
    high      = 0;
    done_at   = -1;
    saw_ready = 0;
    drive(1, v.mode, v.count, v.period);
    ce = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    high += int'(led_out);
    for (int k = 1; k < 400; k++) begin
      ce = ((k % v.ce_div) == 0);
      cyc();
      if (done) begin
        done_at = k;
        break;
      end
      high += int'(led_out);
      if (cmd_ready) saw_ready = 1;
    end
    chk($sformatf("vec%0d_done_at", idx), done_at, v.exp_done);
    chk($sformatf("vec%0d_ready_low", idx), int'(saw_ready), 0);
`ifndef LED_PWM_EN
    chk($sformatf("vec%0d_high", idx), high, v.exp_high);
`endif
  endtask

  initial begin
    int prev;
    int seen;
    rst = 1'b1;
    ce  = 1'b0;
    drive(0, MODE_OFF, 0, 0);
    m_reset();

    tbl[0] = '{MODE_BLINK, 3, 4, 1, 12, 24};
    tbl[1] = '{MODE_PULSE, 0, 2, 5, 10, 10};
    tbl[2] = '{MODE_BLINK, 1, 0, 1, 1, 2};
    tbl[3] = '{MODE_BLINK, 15, 1, 1, 15, 30};
    tbl[4] = '{MODE_PULSE, 0, 3, 2, 6, 6};
    tbl[5] = '{MODE_BLINK, 2, 3, 1, 6, 12};

    // Reset and idle.
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("reset_led", int'(led_out), 0);
    chk("reset_ready", int'(cmd_ready), 1);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Continuous blink then ON preempts.
    ce = 1'b1;
    drive(1, MODE_BLINK, 0, 1);
    cyc();
    cmd_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      prev = int'(led_out);
      cyc();
      chk("cont_toggle", int'(led_out), 1 - prev);
    end
    drive(1, MODE_ON, 0, 0);
    cyc();
    cmd_valid = 1'b0;
    chk("preempt_on_led", int'(led_out), 1);
    chk("preempt_on_done", int'(done), 0);
    cyc();
    drive(1, MODE_OFF, 0, 0);
    cyc();
    cmd_valid = 1'b0;

    // Held command during a finite blink.
    drive(1, MODE_BLINK, 2, 2);
    cyc();
    drive(1, MODE_BLINK, 1, 0);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("held_done_seen", seen, 1);
    chk("held_ready_at_done", int'(cmd_ready), 1);
    cyc();
    cmd_valid = 1'b0;
    chk("held_accept_led", int'(led_out), 1);
    chk("held_accept_busy", int'(busy), 1);
    cyc();
    cyc();
    chk("held_p0_done", int'(done), 1);

    // Async reset mid-blink.
    drive(1, MODE_BLINK, 3, 4);
    cyc();
    drive(1, MODE_ON, 0, 0);
    cmd_valid = 1'b0;
    cyc();
    #2 rst = 1'b1;
    cmd_valid = 1'b1;
    #1;
    m_reset();
    chk("arst_led", int'(led_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    cmd_valid = 1'b0;
    chk("post_rst_on", int'(led_out), int'(m_led()));

`ifdef LED_PWM_EN
    seen = 0;
    for (int k = 0; k < 32; k++) begin
      cyc();
      seen += int'(led_out);
    end
    chk("pwm_high", seen, 2 * PWM_DUTY);
`endif

    // Random commands against the model.
    for (int k = 0; k < 400; k++) begin
      drive($urandom % 2, 2'($urandom % 4),
            int'($urandom % 4), int'($urandom % 4));
      ce = (($urandom % 4) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
